// File: rtl/score_encoder.sv
// score_encoder: rebuilds a binary score from six decimal digits, one digit per clock, MSD first.
module score_encoder #(
  parameter int NUM_DIGITS = 6,
  parameter int DIGIT_W    = 5,
  parameter int SCORE_W    = 25
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DIGIT_W-1:0] hthousands,
  input  logic [DIGIT_W-1:0] tthousands,
  input  logic [DIGIT_W-1:0] thousands,
  input  logic [DIGIT_W-1:0] hundreds,
  input  logic [DIGIT_W-1:0] tens,
  input  logic [DIGIT_W-1:0] ones,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [SCORE_W-1:0] score
);
  localparam int SR_W = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(NUM_DIGITS);
  localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d, digits;
  logic [SCORE_W-1:0] acc_q, acc_d, mac, score_q, score_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic bad_q, bad_d, bad_in, error_q, error_d, go, accum, last, fin;
  assign digits = {hthousands, tthousands, thousands, hundreds, tens, ones};
  assign go     = state_q == IDLE && start;
  assign accum  = state_q == ACCUM;
  assign last   = cnt_q == CNT_W'(NUM_DIGITS - 1);
  assign fin    = accum && last;
  assign mac    = (acc_q << 3) + (acc_q << 1) + SCORE_W'(sr_q[SR_W-1 -: DIGIT_W]);
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) bad_in = bad_in | (digits[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9));
  end
  always_comb begin
    state_d = state_q == IDLE ? (start ? ACCUM : IDLE) : accum ? (last ? DONE : ACCUM) : IDLE;
    sr_d    = go ? digits : accum ? sr_q << DIGIT_W : sr_q;
    acc_d   = go ? '0 : accum ? mac : acc_q;
    cnt_d   = go ? '0 : accum ? cnt_q + CNT_W'(1) : cnt_q;
    bad_d   = go ? bad_in : bad_q;
    // a conversion with any bad digit still runs to completion but keeps the old score
    score_d = fin && !bad_q ? mac : score_q;
    error_d = fin ? bad_q : error_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      score_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      score_q <= score_d;
      error_q <= error_d;
    end
  end
  assign busy  = accum;
  assign done  = state_q == DONE;
  assign error = error_q;
  assign score = score_q;
endmodule

// File: tb/tb_score_encoder.sv
// tb_score_encoder: table-driven and hand-sequenced checks of the digit-to-binary score encoder.
module tb_score_encoder;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [4:0] hth, tth, th, hu, te, on;
  logic busy, done, error;
  logic [24:0] score;
  int n_chk = 0, n_fail = 0;

  score_encoder dut (
    .clk(clk), .reset(reset), .start(start),
    .hthousands(hth), .tthousands(tth), .thousands(th), .hundreds(hu), .tens(te), .ones(on),
    .busy(busy), .done(done), .error(error), .score(score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] d;
    logic [24:0] sc;
    logic        er;
  } vec_t;

  function automatic logic [29:0] dg(input int a, b, c, d, e, f);
    return {5'(a), 5'(b), 5'(c), 5'(d), 5'(e), 5'(f)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic set_digits(input logic [29:0] d);
    {hth, tth, th, hu, te, on} = d;
  endtask

  // start pulse at edge k, then expect busy until done appears after edge k+6
  task automatic convert(input string nm, input logic [29:0] d, input logic [24:0] es, input logic ee);
    int n;
    logic busy_ok;
    set_digits(d);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (!done && n < 20) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, 7);
    chk({nm, " busy"}, {31'd0, busy_ok}, 1);
    chk({nm, " busy_at_done"}, {31'd0, busy}, 0);
    chk({nm, " score"}, {7'd0, score}, {7'd0, es});
    chk({nm, " error"}, {31'd0, error}, {31'd0, ee});
    @(negedge clk);
    chk({nm, " done_one_cycle"}, {31'd0, done}, 0);
  endtask

  vec_t vecs[7];

  initial begin
    int dones, first, second;
    vecs[0] = '{dg(1,2,3,4,5,6), 25'd123456, 1'b0};
    vecs[1] = '{dg(9,9,9,9,9,9), 25'd999999, 1'b0};
    vecs[2] = '{dg(0,0,0,0,0,0), 25'd0,      1'b0};
    vecs[3] = '{dg(9,9,9,9,9,9), 25'd999999, 1'b0};
    vecs[4] = '{dg(0,0,0,0,10,9), 25'd999999, 1'b1};
    vecs[5] = '{dg(0,0,0,0,4,2), 25'd42,     1'b0};
    vecs[6] = '{dg(31,0,0,0,0,0), 25'd42,    1'b1};
    set_digits('0);
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset error", {31'd0, error}, 0);
    chk("reset score", {7'd0, score}, 0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) convert($sformatf("vec%0d", i), vecs[i].d, vecs[i].sc, vecs[i].er);
    convert("v987654", dg(9,8,7,6,5,4), 25'd987654, 1'b0);

    // restart request mid-conversion with new digits must be ignored
    set_digits(dg(1,2,3,4,5,6));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    set_digits(dg(7,7,7,7,7,7));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    repeat (12) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("restart done_count", dones, 1);
    chk("restart score", {7'd0, score}, 123456);

    // reset at edge k+3 abandons the conversion
    convert("pre_reset", dg(0,0,0,0,10,0), 25'd123456, 1'b1);
    set_digits(dg(5,5,5,5,5,5));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset busy", {31'd0, busy}, 0);
    chk("midreset done", {31'd0, done}, 0);
    chk("midreset score", {7'd0, score}, 0);
    chk("midreset error", {31'd0, error}, 0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("midreset no_late_done", {7'd0, score}, 0);
    convert("post_reset", dg(0,0,0,1,0,0), 25'd100, 1'b0);

    // start held high: conversions restart on every IDLE visit
    set_digits(dg(0,0,0,0,0,7));
    start = 1'b1;
    dones = 0;
    first = 0;
    second = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (dones == 1) first = n;
        if (dones == 2) second = n;
        chk($sformatf("held score@%0d", n), {7'd0, score}, 7);
      end
    end
    start = 1'b0;
    chk("held done_count", dones, 2);
    chk("held first_done", first, 7);
    chk("held second_done", second, 15);
    repeat (10) @(negedge clk);
    chk("held final busy", {31'd0, busy}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
